instr_fetch: RTL and testbench

Instruction-fetch controller on the consuming side of the `pc` register. It reads the current PC, issues word reads to instruction memory over a req/ack handshake, and steers the PC by driving its `sel`/`instr` inputs (NEXT on a completed fetch, KEEP while stalled, LOAD on a branch redirect). Fetched words, tagged with their PC, go into a 2-entry buffer and are delivered to decode over a valid/ready handshake.

---
 rtl/processor_defs.sv | 17 +
 rtl/fetch_buffer.sv | 70 +++++++
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_defs.sv
// Encodings shared by the fetch controller and the pc register.
package processor_defs;

    typedef enum logic [1:0] {
        NEXT_INSTR = 2'd0,
        KEEP_INSTR = 2'd1,
        LOAD_INSTR = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} between fetch and decode.
module fetch_buffer #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_pc,
    input  logic [WORD_SIZE-1:0] push_instr,
    input  logic                 pop,
    input  logic                 flush,
    output logic [1:0]           count,
    output logic [WORD_SIZE-1:0] head_pc,
    output logic [WORD_SIZE-1:0] head_instr
);

    logic [WORD_SIZE-1:0] pc_q    [2];
    logic [WORD_SIZE-1:0] pc_d    [2];
    logic [WORD_SIZE-1:0] instr_q [2];
    logic [WORD_SIZE-1:0] instr_d [2];
    logic                 wr_q, wr_d;
    logic                 rd_q, rd_d;
    logic [1:0]           cnt_q, cnt_d;

    // A pop alongside a flush is still a consumed entry; flush wins on state.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push) begin
                pc_d[wr_q]    = push_pc;
                instr_d[wr_q] = push_instr;
                wr_d          = ~wr_q;
            end
            if (pop) begin
                rd_d = ~rd_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
    end

    assign count      = cnt_q;
    assign head_pc    = pc_q[rd_q];
    assign head_instr = instr_q[rd_q];

endmodule

// File: rtl/instr_fetch.sv
// Fetch controller: steers the pc, reads instruction memory,
// and queues {pc, instr} pairs for decode.
module instr_fetch
    import processor_defs::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] pc_addr,
    output logic [1:0]           pc_sel,
    output logic [WORD_SIZE-1:0] pc_target,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 branch_valid,
    input  logic [WORD_SIZE-1:0] branch_target,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr_data,
    output logic [WORD_SIZE-1:0] instr_pc,
    input  logic                 instr_ready
);

    fetch_state_e         state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    pc_sel_e              sel;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic [1:0]           count;
    logic [1:0]           cnt_after;
    logic                 unused_pc_hi;

    assign unused_pc_hi = ^pc_addr[WORD_SIZE-1:ADDR_SIZE];

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready;
    assign cnt_after   = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (branch_valid) begin
                    state_d = mem_ack ? REQ : DRAIN;
                end else if (push && cnt_after == 2'd2) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (branch_valid || pop) begin
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel     = KEEP_INSTR;
        mem_req = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        if (!rst) begin
            unique case (state_q)
                REQ: begin
                    mem_req = 1'b1;
                    if (mem_ack && !branch_valid) begin
                        push = 1'b1;
                        sel  = NEXT_INSTR;
                    end
                end
                DRAIN: mem_req = 1'b1;
                default: ;
            endcase
            if (branch_valid) begin
                sel   = LOAD_INSTR;
                flush = 1'b1;
            end
        end
    end

    // The pc moves on a redirect, so a stale read keeps its captured address.
    assign addr_d   = (state_q == REQ) ? pc_addr[ADDR_SIZE-1:0] : addr_q;
    assign mem_addr = (state_q == DRAIN) ? addr_q : pc_addr[ADDR_SIZE-1:0];

    assign pc_sel    = sel;
    assign pc_target = branch_target;

    fetch_buffer #(
        .WORD_SIZE (WORD_SIZE)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (pc_addr),
        .push_instr (mem_rdata),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head_pc    (instr_pc),
        .head_instr (instr_data)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: pc register and memory models,
// scoreboard of decode deliveries plus per-scenario port checks.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        mem_en;
    int          mem_lat;
    int          lat_cnt;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .pc_sel        (pc_sel),
        .pc_target     (pc_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    // pc register: word-granular increment
    always @(posedge clk) begin
        if (rst) pc_addr <= 32'h0;
        else if (pc_sel == 2'd0) pc_addr <= pc_addr + 32'd1;
        else if (pc_sel == 2'd2) pc_addr <= pc_target;
    end

    assign mem_ack   = mem_en && mem_req && (lat_cnt >= mem_lat);
    assign mem_rdata = 32'(mem_addr) + 32'h100;

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid && instr_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL decode_extra: got pc=%h instr=%h, none expected", instr_pc, instr_data);
            end else begin
                e = sb.pop_front();
                if (instr_pc !== e.pc || instr_data !== e.instr) begin
                    fails++;
                    $display("FAIL decode_data: got pc=%h instr=%h expected pc=%h instr=%h",
                             instr_pc, instr_data, e.pc, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input logic [31:0] p, input logic [31:0] d);
        exp_t e;
        e.pc = p;
        e.instr = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        instr_ready = 1'b0;
        branch_valid = 1'b0;
        branch_target = 32'h0;
        mem_en = 1'b1;
        mem_lat = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        tick();
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b expected 0", mem_req); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        tests++; if (pc_sel !== 2'd1) begin fails++; $display("FAIL rst_sel: got %0d expected 1", pc_sel); end
        rst = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0 || pc_sel !== 2'd1) begin fails++; $display("FAIL idle_out: got req=%b sel=%0d expected req=0 sel=1", mem_req, pc_sel); end
        tick();
        tests++; if (mem_req !== 1'b1 || mem_addr !== 14'h0) begin fails++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", mem_req, mem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) expect_push(32'(i), 32'(i) + 32'h100);
        for (int i = 0; i < 8; i++) begin
            tick();
            #1;
            tests++;
            if (mem_req !== 1'b1 || mem_addr !== 14'(i) || pc_sel !== 2'd0) begin
                fails++;
                $display("FAIL stream_req%0d: got req=%b addr=%h sel=%0d expected req=1 addr=%h sel=0",
                         i, mem_req, mem_addr, pc_sel, 14'(i));
            end
        end
        instr_ready = 1'b0;
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL stream_left: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        expect_push(32'h0, 32'h100);
        expect_push(32'h1, 32'h101);
        tick();
        tick();
        tick();
        #1;
        tests++; if (mem_req !== 1'b0 || pc_sel !== 2'd1) begin fails++; $display("FAIL bp_wait: got req=%b sel=%0d expected req=0 sel=1", mem_req, pc_sel); end
        tests++; if (pc_addr !== 32'h2) begin fails++; $display("FAIL bp_pc: got %h expected 2", pc_addr); end
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin fails++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", instr_valid, instr_pc); end
        tick();
        #1;
        tests++; if (mem_req !== 1'b0 || pc_addr !== 32'h2) begin fails++; $display("FAIL bp_hold: got req=%b pc=%h expected req=0 pc=2", mem_req, pc_addr); end
        instr_ready = 1'b1;
        tick();
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 14'h2) begin fails++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=2", mem_req, mem_addr); end
        tick();
        instr_ready = 1'b0;
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL bp_left: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_latency();
        do_reset();
        mem_lat = 2;
        instr_ready = 1'b1;
        expect_push(32'h0, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            tests++;
            if (mem_req !== 1'b1 || mem_addr !== 14'h0 || pc_sel !== (i == 2 ? 2'd0 : 2'd1)) begin
                fails++;
                $display("FAIL lat_cyc%0d: got req=%b addr=%h sel=%0d expected req=1 addr=0 sel=%0d",
                         i, mem_req, mem_addr, pc_sel, (i == 2 ? 0 : 1));
            end
        end
        tick();
        #1;
        tests++; if (mem_addr !== 14'h1 || pc_sel !== 2'd1) begin fails++; $display("FAIL lat_next: got addr=%h sel=%0d expected addr=1 sel=1", mem_addr, pc_sel); end
        tick();
        instr_ready = 1'b0;
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL lat_left: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_branch_drain();
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) expect_push(32'(i), 32'(i) + 32'h100);
        repeat (5) tick();
        tick();
        mem_en = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 14'h5 || mem_ack !== 1'b0) begin fails++; $display("FAIL br_pend: got req=%b addr=%h expected req=1 addr=5", mem_req, mem_addr); end
        tick();
        branch_valid = 1'b1;
        branch_target = 32'h40;
        #1;
        tests++; if (pc_sel !== 2'd2 || pc_target !== 32'h40) begin fails++; $display("FAIL br_load: got sel=%0d tgt=%h expected sel=2 tgt=40", pc_sel, pc_target); end
        tick();
        branch_valid = 1'b0;
        expect_push(32'h40, 32'h140);
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 14'h5 || pc_sel !== 2'd1) begin fails++; $display("FAIL br_drain: got req=%b addr=%h sel=%0d expected req=1 addr=5 sel=1", mem_req, mem_addr, pc_sel); end
        tests++; if (pc_addr !== 32'h40 || instr_valid !== 1'b0) begin fails++; $display("FAIL br_pc: got pc=%h v=%b expected pc=40 v=0", pc_addr, instr_valid); end
        tick();
        mem_en = 1'b1;
        #1;
        tests++; if (mem_ack !== 1'b1 || mem_addr !== 14'h5 || pc_sel !== 2'd1) begin fails++; $display("FAIL br_stale_ack: got ack=%b addr=%h sel=%0d expected ack=1 addr=5 sel=1", mem_ack, mem_addr, pc_sel); end
        tick();
        #1;
        tests++; if (mem_addr !== 14'h40 || pc_sel !== 2'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL br_target_req: got addr=%h sel=%0d v=%b expected addr=40 sel=0 v=0", mem_addr, pc_sel, instr_valid); end
        tick();
        #1;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin fails++; $display("FAIL br_target_data: got v=%b pc=%h expected v=1 pc=40", instr_valid, instr_pc); end
        tick();
        instr_ready = 1'b0;
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL br_left: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_branch_ack_pop();
        do_reset();
        expect_push(32'h0, 32'h100);
        expect_push(32'h20, 32'h120);
        tick();
        tick();
        tick();
        instr_ready = 1'b1;
        branch_valid = 1'b1;
        branch_target = 32'h80;
        #1;
        tests++; if (instr_valid !== 1'b1 || mem_req !== 1'b0 || pc_sel !== 2'd2) begin fails++; $display("FAIL bap_full: got v=%b req=%b sel=%0d expected v=1 req=0 sel=2", instr_valid, mem_req, pc_sel); end
        tick();
        branch_target = 32'h20;
        #1;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL bap_flush: got v=%b expected 0", instr_valid); end
        tests++; if (mem_addr !== 14'h80 || mem_ack !== 1'b1 || pc_sel !== 2'd2) begin fails++; $display("FAIL bap_ackbr: got addr=%h ack=%b sel=%0d expected addr=80 ack=1 sel=2", mem_addr, mem_ack, pc_sel); end
        tick();
        branch_valid = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || mem_addr !== 14'h20 || pc_sel !== 2'd0) begin fails++; $display("FAIL bap_drop: got v=%b addr=%h sel=%0d expected v=0 addr=20 sel=0", instr_valid, mem_addr, pc_sel); end
        tick();
        #1;
        tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20) begin fails++; $display("FAIL bap_data: got v=%b pc=%h expected v=1 pc=20", instr_valid, instr_pc); end
        tick();
        instr_ready = 1'b0;
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL bap_left: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        instr_ready = 1'b1;
        expect_push(32'h3FFF, 32'h40FF);
        expect_push(32'h4000, 32'h100);
        tick();
        branch_valid = 1'b1;
        branch_target = 32'h3FFF;
        #1;
        tests++; if (pc_sel !== 2'd2 || mem_ack !== 1'b1) begin fails++; $display("FAIL wrap_br: got sel=%0d ack=%b expected sel=2 ack=1", pc_sel, mem_ack); end
        tick();
        branch_valid = 1'b0;
        #1;
        tests++; if (mem_addr !== 14'h3FFF || instr_valid !== 1'b0) begin fails++; $display("FAIL wrap_hi: got addr=%h v=%b expected addr=3fff v=0", mem_addr, instr_valid); end
        tick();
        #1;
        tests++; if (pc_addr !== 32'h4000 || mem_addr !== 14'h0) begin fails++; $display("FAIL wrap_lo: got pc=%h addr=%h expected pc=4000 addr=0", pc_addr, mem_addr); end
        tick();
        #1;
        tests++; if (instr_pc !== 32'h4000) begin fails++; $display("FAIL wrap_pc: got %h expected 4000", instr_pc); end
        tick();
        instr_ready = 1'b0;
        mem_en = 1'b0;
        tick();
        branch_valid = 1'b1;
        branch_target = 32'h10;
        tick();
        branch_valid = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 14'h2 || instr_valid !== 1'b0) begin fails++; $display("FAIL rd_drain: got req=%b addr=%h v=%b expected req=1 addr=2 v=0", mem_req, mem_addr, instr_valid); end
        rst = 1'b1;
        #1;
        tests++; if (mem_req !== 1'b0 || pc_sel !== 2'd1) begin fails++; $display("FAIL rd_rstcomb: got req=%b sel=%0d expected req=0 sel=1", mem_req, pc_sel); end
        tick();
        rst = 1'b0;
        mem_en = 1'b1;
        #1;
        tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc_sel !== 2'd1) begin fails++; $display("FAIL rd_idle: got v=%b req=%b sel=%0d expected v=0 req=0 sel=1", instr_valid, mem_req, pc_sel); end
        tick();
        #1;
        tests++; if (mem_req !== 1'b1 || mem_addr !== 14'h0) begin fails++; $display("FAIL rd_restart: got req=%b addr=%h expected req=1 addr=0", mem_req, mem_addr); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL wrap_left: got %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_latency();
        test_branch_drain();
        test_branch_ack_pop();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
